// File: rtl/ops_decoder.sv
// ops_decoder: memory-control decoder for micro-op words, gated by an IDLE/RUN controller.
// Ports: CLK, RESET (async, active-low), uOPs, START in; DREAD, IREAD, DWRITE, BUSMEM, MEMBUSI out.
// Optional: define OPS_DECODER_CONFLICT_FLAG_EN to add the registered CONFLICT output.
module ops_decoder #(
    parameter int UOP_W    = 49,
    parameter int MCTL_LSB = 0,
    parameter int HALT_BIT = 48
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [UOP_W-1:0] uOPs,
    input  logic             START,
    output logic             DREAD,
    output logic             IREAD,
    output logic             DWRITE,
    output logic             BUSMEM,
`ifdef OPS_DECODER_CONFLICT_FLAG_EN
    output logic             CONFLICT,
`endif
    output logic             MEMBUSI
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // Memory-control request bits
    logic [4:0] mctl;
    logic       req_r;
    logic       req_i;
    logic       req_w;
    logic       req_b;
    logic       req_m;
    logic       halt;

    assign mctl  = uOPs[MCTL_LSB +: 5];
    assign req_r = mctl[0];
    assign req_i = mctl[1];
    assign req_w = mctl[2];
    assign req_b = mctl[3];
    assign req_m = mctl[4];
    assign halt  = uOPs[HALT_BIT];

    // Remaining micro-op bits belong to other decoders
    logic unused_uop_bits;
    assign unused_uop_bits = ^uOPs;

    // One access per cycle, W > R > I; path enables follow their access
    logic g_w;
    logic g_r;
    logic g_i;
    logic g_b;
    logic g_m;

    assign g_w = req_w;
    assign g_r = req_r & ~req_w;
    assign g_i = req_i & ~req_r & ~req_w;
    assign g_b = req_b & g_w;
    assign g_m = req_m & g_i;

    logic dread_d;
    logic iread_d;
    logic dwrite_d;
    logic busmem_d;
    logic membusi_d;

`ifdef OPS_DECODER_CONFLICT_FLAG_EN
    logic multi_acc;
    logic conflict_d;

    // Flags requests the grant logic had to drop or ignore
    assign multi_acc = (req_r & req_i) | (req_r & req_w) | (req_i & req_w);
`endif

    // Next state and next output values
    always_comb begin
        state_d   = state_q;
        dread_d   = 1'b0;
        iread_d   = 1'b0;
        dwrite_d  = 1'b0;
        busmem_d  = 1'b0;
        membusi_d = 1'b0;
`ifdef OPS_DECODER_CONFLICT_FLAG_EN
        conflict_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                // uOPs is not looked at here, so X words cannot leak out
                if (START) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (halt) begin
                    state_d = IDLE;
                end else begin
                    dread_d   = g_r;
                    iread_d   = g_i;
                    dwrite_d  = g_w;
                    busmem_d  = g_b;
                    membusi_d = g_m;
`ifdef OPS_DECODER_CONFLICT_FLAG_EN
                    conflict_d = multi_acc
                               | (req_b & ~req_w)
                               | (req_m & ~req_i);
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            DREAD   <= 1'b0;
            IREAD   <= 1'b0;
            DWRITE  <= 1'b0;
            BUSMEM  <= 1'b0;
            MEMBUSI <= 1'b0;
        end else begin
            DREAD   <= dread_d;
            IREAD   <= iread_d;
            DWRITE  <= dwrite_d;
            BUSMEM  <= busmem_d;
            MEMBUSI <= membusi_d;
        end
    end

`ifdef OPS_DECODER_CONFLICT_FLAG_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            CONFLICT <= 1'b0;
        end else begin
            CONFLICT <= conflict_d;
        end
    end
`endif

endmodule

// File: tb/tb_ops_decoder.sv
// tb_ops_decoder: directed and randomized checks of ops_decoder
// against a behavioural model of the run controller and grant rules.
module tb_ops_decoder;

    logic        clk;
    logic        rst_n;
    logic [48:0] uops;
    logic        start;
    logic        dread;
    logic        iread;
    logic        dwrite;
    logic        busmem;
    logic        membusi;
    logic        conflict;

    int checks = 0;
    int errors = 0;

    // Model state: running flag and expected
    // {CONFLICT, MEMBUSI, BUSMEM, DWRITE, IREAD, DREAD}
    bit         m_run;
    logic [5:0] m_exp;

    ops_decoder dut (
        .CLK     (clk),
        .RESET   (rst_n),
        .uOPs    (uops),
        .START   (start),
        .DREAD   (dread),
        .IREAD   (iread),
        .DWRITE  (dwrite),
        .BUSMEM  (busmem),
`ifdef OPS_DECODER_CONFLICT_FLAG_EN
        .CONFLICT(conflict),
`endif
        .MEMBUSI (membusi)
    );

`ifndef OPS_DECODER_CONFLICT_FLAG_EN
    assign conflict = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] obs();
        return {conflict, membusi, busmem, dwrite, iread, dread};
    endfunction

    // Decoded outputs for one non-halt micro-op while running
    function automatic logic [5:0] ref_decode(input logic [4:0] m);
        logic [5:0] e;
        int         nacc;
        e = '0;
        if (m[2]) begin
            e[2] = 1'b1;
            e[3] = m[3];
        end else if (m[0]) begin
            e[0] = 1'b1;
        end else if (m[1]) begin
            e[1] = 1'b1;
            e[4] = m[4];
        end
        nacc = int'(m[0]) + int'(m[1]) + int'(m[2]);
`ifdef OPS_DECODER_CONFLICT_FLAG_EN
        e[5] = (nacc > 1) || (m[3] && !m[2]) || (m[4] && !m[1]);
`else
        e[5] = 1'b0;
        if (nacc > 3) e[5] = 1'b1;
`endif
        return e;
    endfunction

    task automatic model_edge(input logic [48:0] u, input logic s);
        if (!m_run) begin
            m_exp = '0;
            if (s === 1'b1) m_run = 1'b1;
        end else if (u[48]) begin
            m_exp = '0;
            m_run = 1'b0;
        end else begin
            m_exp = ref_decode(u[4:0]);
        end
    endtask

    task automatic check(input string tag, input logic [5:0] o, input logic [5:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic check_inv(input string tag);
        logic [5:0] o;
        o = obs();
        checks++;
        assert ((int'(o[0]) + int'(o[1]) + int'(o[2]) <= 1)
                && (!o[3] || o[2]) && (!o[4] || o[1])) else begin
            errors++;
            $error("FAIL %s observed=%b expected=one-hot-access", tag, o);
        end
    endtask

    task automatic step(input string tag, input logic [48:0] u, input logic s);
        uops  = u;
        start = s;
        @(posedge clk);
        model_edge(u, s);
        @(negedge clk);
        check(tag, obs(), m_exp);
    endtask

    initial begin
        logic [48:0] u;
        uops  = '0;
        start = 1'b0;
        rst_n = 1'b0;
        m_run = 1'b0;
        m_exp = '0;
        #1;
        check("reset", obs(), 6'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle: uOPs ignored without START
        for (int i = 0; i < 3; i++) step("idle", 49'd1, 1'b0);
        step("idle_x", 'x, 1'b0);

        // Start and basic decode
        step("start", 49'd0, 1'b1);
        step("dec_0", 49'd0, 1'b0);
        step("dec_r", 49'd1, 1'b0);
        step("dec_i", 49'd2, 1'b0);
        step("dec_wb", 49'h0C, 1'b0);
        step("dec_im", 49'h12, 1'b0);

        // Priority
        step("prio_w", 49'd2678, 1'b0);
        step("prio_r", 49'h03, 1'b0);

        // Halt, then START=0 keeps idle
        step("halt", (49'd1 << 48) | 49'd1, 1'b0);
        step("post_halt", 49'd1, 1'b0);

        // Async reset mid-run while DWRITE is high
        step("restart", 49'd0, 1'b1);
        step("dw_on", 49'h04, 1'b0);
        #2;
        rst_n = 1'b0;
        m_run = 1'b0;
        m_exp = '0;
        #1;
        check("async_rst", obs(), 6'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 49'd1, 1'b0);
        step("post_rst2", 49'h04, 1'b0);

        // Randomized run against the model
        for (int i = 0; i < 300; i++) begin
            u = 49'({$urandom(), $urandom()});
            u[48] = ($urandom_range(0, 11) == 0);
            step("rand", u, 1'($urandom_range(0, 1)));
            check_inv("invariant");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
